// File: rtl/bru_redirect_ctrl.sv
// bru_redirect_ctrl: branch-mispredict recovery sequencer (restore checkpoint, kill younger ROB entries, redirect fetch)
// Ports: clk/rst (async active-low); bru_* resolved-branch report; rob_head_id for age compare;
// commit_flush overrides all; cp_restore_*/kill_* one-cycle strobes; fetch_redirect_* valid/ready
// handshake; busy = not idle; mispredict_count saturating count of captured mispredicts.
module bru_redirect_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int ROB_ID_WIDTH = 5,
  parameter int CHECKPOINT_ID_WIDTH = 4,
  parameter int HOLDOFF_CYCLES = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           bru_valid,
  input  logic [ROB_ID_WIDTH-1:0]        bru_rob_id,
  input  logic [CHECKPOINT_ID_WIDTH-1:0] bru_checkpoint_id,
  input  logic                           bru_jump,
  input  logic [ADDR_WIDTH-1:0]          bru_next_pc,
  input  logic                           bru_predicted_jump,
  input  logic [ADDR_WIDTH-1:0]          bru_predicted_next_pc,
  input  logic [ROB_ID_WIDTH-1:0]        rob_head_id,
  input  logic                           commit_flush,
  output logic                           cp_restore_valid,
  output logic [CHECKPOINT_ID_WIDTH-1:0] cp_restore_id,
  output logic                           kill_valid,
  output logic [ROB_ID_WIDTH-1:0]        kill_rob_id,
  output logic                           fetch_redirect_valid,
  output logic [ADDR_WIDTH-1:0]          fetch_redirect_pc,
  input  logic                           fetch_redirect_ready,
  output logic                           busy,
  output logic [31:0]                    mispredict_count
);
  typedef enum logic [1:0] {IDLE, RESTORE, REDIRECT, HOLDOFF} state_t;
  state_t state_q, state_d;
  logic [ROB_ID_WIDTH-1:0] pend_rob_q, pend_rob_d, age_new, age_pend;
  logic [CHECKPOINT_ID_WIDTH-1:0] pend_cp_q, pend_cp_d;
  logic [ADDR_WIDTH-1:0] pend_pc_q, pend_pc_d;
  logic [3:0] cnt_q, cnt_d;
  logic [31:0] count_q, count_d;
  logic mispredict, capture;
  always_comb begin
    mispredict = bru_valid && (bru_jump != bru_predicted_jump ||
                 (bru_jump && bru_next_pc != bru_predicted_next_pc));
    // ages wrap modulo ROB depth; equal age is the pending branch itself
    age_new = bru_rob_id - rob_head_id;
    age_pend = pend_rob_q - rob_head_id;
    capture = mispredict && !commit_flush && (state_q == IDLE || age_new < age_pend);
    pend_rob_d = capture ? bru_rob_id : pend_rob_q;
    pend_cp_d = capture ? bru_checkpoint_id : pend_cp_q;
    pend_pc_d = capture ? bru_next_pc : pend_pc_q;
    count_d = (capture && !(&count_q)) ? count_q + 32'd1 : count_q;
    state_d = state_q;
    cnt_d = cnt_q;
    if (commit_flush) state_d = IDLE;
    else if (capture) state_d = RESTORE;
    else
      case (state_q)
        RESTORE: state_d = REDIRECT;
        REDIRECT:
          if (fetch_redirect_ready) begin
            state_d = (HOLDOFF_CYCLES == 0) ? IDLE : HOLDOFF;
            cnt_d = 4'(HOLDOFF_CYCLES);
          end
        HOLDOFF: begin
          cnt_d = cnt_q - 4'd1;
          state_d = (cnt_q <= 4'd1) ? IDLE : HOLDOFF;
        end
        default: state_d = IDLE;
      endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      pend_rob_q <= '0;
      pend_cp_q <= '0;
      pend_pc_q <= '0;
      cnt_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      pend_rob_q <= pend_rob_d;
      pend_cp_q <= pend_cp_d;
      pend_pc_q <= pend_pc_d;
      cnt_q <= cnt_d;
      count_q <= count_d;
    end
  end
  assign cp_restore_valid = state_q == RESTORE;
  assign kill_valid = state_q == RESTORE;
  assign cp_restore_id = pend_cp_q;
  assign kill_rob_id = pend_rob_q;
  assign fetch_redirect_valid = state_q == REDIRECT;
  assign fetch_redirect_pc = pend_pc_q;
  assign busy = state_q != IDLE;
  assign mispredict_count = count_q;
endmodule

// File: tb/tb_bru_redirect_ctrl.sv
// tb_bru_redirect_ctrl: self-checking bench for bru_redirect_ctrl
module tb_bru_redirect_ctrl;
  logic clk = 0, rst = 0;
  logic bru_valid = 0, bru_jump = 0, bru_predicted_jump = 0;
  logic [4:0] bru_rob_id = 0, rob_head_id = 0, kill_rob_id;
  logic [3:0] bru_checkpoint_id = 0, cp_restore_id;
  logic [31:0] bru_next_pc = 0, bru_predicted_next_pc = 0, fetch_redirect_pc, mispredict_count;
  logic commit_flush = 0, fetch_redirect_ready = 0;
  logic cp_restore_valid, kill_valid, fetch_redirect_valid, busy;
  typedef struct {logic [3:0] cp; logic [4:0] rob;} rq_t;
  rq_t rq[$];
  logic [31:0] pq[$];
  rq_t e;
  logic [31:0] ep;
  int checks = 0, errors = 0;
  logic [31:0] exp_count = 0;
  bit to;

  always #5 clk = ~clk;

  bru_redirect_ctrl dut (
    .clk(clk), .rst(rst), .bru_valid(bru_valid), .bru_rob_id(bru_rob_id),
    .bru_checkpoint_id(bru_checkpoint_id), .bru_jump(bru_jump), .bru_next_pc(bru_next_pc),
    .bru_predicted_jump(bru_predicted_jump), .bru_predicted_next_pc(bru_predicted_next_pc),
    .rob_head_id(rob_head_id), .commit_flush(commit_flush),
    .cp_restore_valid(cp_restore_valid), .cp_restore_id(cp_restore_id),
    .kill_valid(kill_valid), .kill_rob_id(kill_rob_id),
    .fetch_redirect_valid(fetch_redirect_valid), .fetch_redirect_pc(fetch_redirect_pc),
    .fetch_redirect_ready(fetch_redirect_ready), .busy(busy), .mispredict_count(mispredict_count)
  );

  // scoreboard: every restore pulse and every accepted redirect pops one expectation
  always @(negedge clk) begin
    if (rst) begin
      if (cp_restore_valid) begin
        checks++;
        if (rq.size() == 0) begin
          errors++;
          $display("FAIL restore_unexpected got cp %0h rob %0h want none", cp_restore_id, kill_rob_id);
        end else begin
          e = rq.pop_front();
          if (cp_restore_id !== e.cp || kill_rob_id !== e.rob || kill_valid !== 1'b1) begin
            errors++;
            $display("FAIL restore got cp %0h rob %0h kill %0b want cp %0h rob %0h kill 1",
                     cp_restore_id, kill_rob_id, kill_valid, e.cp, e.rob);
          end
        end
      end
      if (fetch_redirect_valid && fetch_redirect_ready) begin
        checks++;
        if (pq.size() == 0) begin
          errors++;
          $display("FAIL redirect_unexpected got pc %0h want none", fetch_redirect_pc);
        end else begin
          ep = pq.pop_front();
          if (fetch_redirect_pc !== ep) begin
            errors++;
            $display("FAIL redirect_pc got %0h want %0h", fetch_redirect_pc, ep);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_br(input logic [4:0] rob, input logic [3:0] cp, input logic j,
                          input logic [31:0] pc, input logic pj, input logic [31:0] ppc);
    bru_valid = 1;
    bru_rob_id = rob;
    bru_checkpoint_id = cp;
    bru_jump = j;
    bru_next_pc = pc;
    bru_predicted_jump = pj;
    bru_predicted_next_pc = ppc;
  endtask

  task automatic push_exp(input logic [4:0] rob, input logic [3:0] cp, input logic [31:0] pc,
                          input bit redirect);
    rq.push_back('{cp: cp, rob: rob});
    if (redirect) pq.push_back(pc);
    exp_count++;
  endtask

  task automatic wait_idle(output bit timed_out);
    timed_out = 1;
    for (int i = 0; i < 20; i++) begin
      if (!busy) begin
        timed_out = 0;
        return;
      end
      step();
    end
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({cp_restore_valid, kill_valid, fetch_redirect_valid, busy, mispredict_count,
         fetch_redirect_pc, cp_restore_id, kill_rob_id} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got busy %0b count %0h pc %0h want all 0", busy, mispredict_count, fetch_redirect_pc);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1;
    step();
    checks++;
    if (busy !== 0 || mispredict_count !== 0) begin
      errors++;
      $display("FAIL reset_release got busy %0b count %0h want 0 0", busy, mispredict_count);
    end
  endtask

  task automatic test_direction();
    rob_head_id = 0;
    step();
    drive_br(3, 2, 1, 32'h8000_0100, 0, 32'h0);
    push_exp(3, 2, 32'h8000_0100, 1);
    step();
    bru_valid = 0;
    checks++;
    if (cp_restore_valid !== 1 || busy !== 1 || fetch_redirect_valid !== 0) begin
      errors++;
      $display("FAIL dir_n1 got restore %0b busy %0b redir %0b want 1 1 0", cp_restore_valid, busy, fetch_redirect_valid);
    end
    step();
    checks++;
    if (fetch_redirect_valid !== 1 || fetch_redirect_pc !== 32'h8000_0100 || cp_restore_valid !== 0) begin
      errors++;
      $display("FAIL dir_n2 got redir %0b pc %0h restore %0b want 1 80000100 0", fetch_redirect_valid, fetch_redirect_pc, cp_restore_valid);
    end
    fetch_redirect_ready = 1;
    step();
    fetch_redirect_ready = 0;
    checks++;
    if (fetch_redirect_valid !== 0 || busy !== 1) begin
      errors++;
      $display("FAIL dir_n3 got redir %0b busy %0b want 0 1", fetch_redirect_valid, busy);
    end
    step();
    checks++;
    if (busy !== 1) begin
      errors++;
      $display("FAIL dir_n4_holdoff got busy %0b want 1", busy);
    end
    step();
    checks++;
    if (busy !== 0 || mispredict_count !== exp_count) begin
      errors++;
      $display("FAIL dir_n5 got busy %0b count %0h want 0 %0h", busy, mispredict_count, exp_count);
    end
  endtask

  task automatic test_target();
    fetch_redirect_ready = 1;
    drive_br(4, 6, 1, 32'h200, 1, 32'h240);
    push_exp(4, 6, 32'h200, 1);
    step();
    bru_valid = 0;
    wait_idle(to);
    fetch_redirect_ready = 0;
    checks++;
    if (to || mispredict_count !== exp_count) begin
      errors++;
      $display("FAIL target got timeout %0b count %0h want 0 %0h", to, mispredict_count, exp_count);
    end
    drive_br(6, 1, 0, 32'h300, 0, 32'h340);
    step();
    bru_valid = 0;
    checks++;
    if (busy !== 0 || cp_restore_valid !== 0 || mispredict_count !== exp_count) begin
      errors++;
      $display("FAIL not_taken_pc_diff got busy %0b count %0h want 0 %0h", busy, mispredict_count, exp_count);
    end
  endtask

  task automatic test_replace();
    rob_head_id = 0;
    drive_br(5, 5, 1, 32'h500, 0, 32'h0);
    push_exp(5, 5, 32'h500, 0);
    step();
    bru_valid = 0;
    step();
    checks++;
    if (fetch_redirect_valid !== 1 || fetch_redirect_pc !== 32'h500) begin
      errors++;
      $display("FAIL replace_first got redir %0b pc %0h want 1 500", fetch_redirect_valid, fetch_redirect_pc);
    end
    drive_br(2, 1, 1, 32'h300, 0, 32'h0);
    push_exp(2, 1, 32'h300, 1);
    step();
    bru_valid = 0;
    checks++;
    if (fetch_redirect_valid !== 0 || cp_restore_valid !== 1) begin
      errors++;
      $display("FAIL replace_withdraw got redir %0b restore %0b want 0 1", fetch_redirect_valid, cp_restore_valid);
    end
    step();
    checks++;
    if (fetch_redirect_valid !== 1 || fetch_redirect_pc !== 32'h300) begin
      errors++;
      $display("FAIL replace_redirect got redir %0b pc %0h want 1 300", fetch_redirect_valid, fetch_redirect_pc);
    end
    fetch_redirect_ready = 1;
    wait_idle(to);
    fetch_redirect_ready = 0;
    checks++;
    if (to || mispredict_count !== exp_count) begin
      errors++;
      $display("FAIL replace_end got timeout %0b count %0h want 0 %0h", to, mispredict_count, exp_count);
    end
  endtask

  task automatic test_wrap();
    rob_head_id = 30;
    drive_br(31, 3, 1, 32'h700, 0, 32'h0);
    push_exp(31, 3, 32'h700, 1);
    step();
    drive_br(1, 9, 1, 32'h800, 0, 32'h0);
    step();
    step();
    bru_valid = 0;
    checks++;
    if (fetch_redirect_valid !== 1 || fetch_redirect_pc !== 32'h700 || mispredict_count !== exp_count) begin
      errors++;
      $display("FAIL younger_ignored got redir %0b pc %0h count %0h want 1 700 %0h",
               fetch_redirect_valid, fetch_redirect_pc, mispredict_count, exp_count);
    end
    fetch_redirect_ready = 1;
    wait_idle(to);
    fetch_redirect_ready = 0;
    drive_br(1, 4, 1, 32'h900, 0, 32'h0);
    push_exp(1, 4, 32'h900, 0);
    step();
    drive_br(31, 6, 0, 32'ha00, 1, 32'h0);
    push_exp(31, 6, 32'ha00, 1);
    step();
    bru_valid = 0;
    checks++;
    if (cp_restore_valid !== 1 || fetch_redirect_valid !== 0) begin
      errors++;
      $display("FAIL wrap_replace got restore %0b redir %0b want 1 0", cp_restore_valid, fetch_redirect_valid);
    end
    step();
    checks++;
    if (fetch_redirect_pc !== 32'ha00 || fetch_redirect_valid !== 1) begin
      errors++;
      $display("FAIL wrap_redirect got redir %0b pc %0h want 1 a00", fetch_redirect_valid, fetch_redirect_pc);
    end
    fetch_redirect_ready = 1;
    wait_idle(to);
    fetch_redirect_ready = 0;
    checks++;
    if (to || mispredict_count !== exp_count) begin
      errors++;
      $display("FAIL wrap_end got timeout %0b count %0h want 0 %0h", to, mispredict_count, exp_count);
    end
  endtask

  task automatic test_flush();
    rob_head_id = 0;
    drive_br(4, 2, 1, 32'hc00, 0, 32'h0);
    commit_flush = 1;
    step();
    bru_valid = 0;
    commit_flush = 0;
    checks++;
    if (busy !== 0 || cp_restore_valid !== 0 || mispredict_count !== exp_count) begin
      errors++;
      $display("FAIL flush_idle got busy %0b count %0h want 0 %0h", busy, mispredict_count, exp_count);
    end
    fetch_redirect_ready = 1;
    drive_br(7, 8, 1, 32'hd00, 0, 32'h0);
    push_exp(7, 8, 32'hd00, 1);
    step();
    bru_valid = 0;
    step();
    step();
    fetch_redirect_ready = 0;
    checks++;
    if (busy !== 1 || fetch_redirect_valid !== 0) begin
      errors++;
      $display("FAIL flush_pre_holdoff got busy %0b redir %0b want 1 0", busy, fetch_redirect_valid);
    end
    commit_flush = 1;
    step();
    commit_flush = 0;
    checks++;
    if (busy !== 0 || mispredict_count !== exp_count) begin
      errors++;
      $display("FAIL flush_holdoff got busy %0b count %0h want 0 %0h", busy, mispredict_count, exp_count);
    end
  endtask

  task automatic test_reset_mid_redirect();
    drive_br(9, 3, 1, 32'hb00, 0, 32'h0);
    push_exp(9, 3, 32'hb00, 0);
    step();
    bru_valid = 0;
    step();
    checks++;
    if (fetch_redirect_valid !== 1) begin
      errors++;
      $display("FAIL mid_redirect_setup got redir %0b want 1", fetch_redirect_valid);
    end
    #2 rst = 0;
    #1;
    checks++;
    if ({cp_restore_valid, kill_valid, fetch_redirect_valid, busy, mispredict_count,
         fetch_redirect_pc, cp_restore_id, kill_rob_id} !== '0) begin
      errors++;
      $display("FAIL async_reset got redir %0b pc %0h busy %0b count %0h want all 0",
               fetch_redirect_valid, fetch_redirect_pc, busy, mispredict_count);
    end
    #3 rst = 1;
    exp_count = 0;
    step();
    checks++;
    if (busy !== 0 || fetch_redirect_valid !== 0 || mispredict_count !== exp_count) begin
      errors++;
      $display("FAIL reset_release_mid got busy %0b count %0h want 0 0", busy, mispredict_count);
    end
  endtask

  initial begin
    test_reset();
    test_direction();
    test_target();
    test_replace();
    test_wrap();
    test_flush();
    test_reset_mid_redirect();
    checks++;
    if (rq.size() != 0 || pq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got restores %0d redirects %0d left want 0 0", rq.size(), pq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
